// File: rtl/uart_rx_sipo_param_if.sv
// uart_rx_sipo_param_if: serial line, delivered word, status flags and consumer handshake
interface uart_rx_sipo_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 active;
    modport master (
        output rx_in, data_ready,
        input  data_out, data_valid, parity_err, frame_err, overrun, active
    );
    modport slave (
        input  rx_in, data_ready,
        output data_out, data_valid, parity_err, frame_err, overrun, active
    );
endinterface

// File: rtl/uart_rx_sipo_param.sv
// uart_rx_sipo_param: one-sample-per-bit UART receiver with a single holding register and overrun detection
module uart_rx_sipo_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input logic                 baud_clk,
    input logic                 rst,
    uart_rx_sipo_param_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_D = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_S = CW'(STOP_BITS - 1);
    localparam logic ODD = (PARITY_MODE == 2);
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_rx_sipo_param: illegal parameter value");
    end
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 perr_q, perr_d;
    logic                 facc_q, facc_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        facc_d  = facc_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.rx_in ? IDLE : DATA;
                cnt_d   = '0;
                facc_d  = 1'b0;
            end
            DATA: begin
                shift_d = {bus.rx_in, shift_q[DATA_BITS-1:1]};
                cnt_d   = (cnt_q == LAST_D) ? '0 : cnt_q + 1'b1;
                if (cnt_q == LAST_D) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: begin
                perr_d  = (^shift_q) ^ bus.rx_in ^ ODD;
                state_d = STOP;
                cnt_d   = '0;
            end
            default: begin
                facc_d = facc_q | ~bus.rx_in;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_S) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    facc_d  = 1'b0;
                    // A pending word not being consumed on this edge wins; the new frame is dropped
                    if (!valid_q || bus.data_ready) begin
                        dout_d  = shift_q;
                        pe_d    = perr_q;
                        fe_d    = facc_q | ~bus.rx_in;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (valid_q && bus.data_ready) begin
                    valid_d = 1'b0;
                end
            end
        endcase
        if (state_q != STOP && valid_q && bus.data_ready) valid_d = 1'b0;
    end
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            facc_q  <= 1'b0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            facc_q  <= facc_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.overrun    = ovr_q;
    assign bus.active     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_sipo_param.sv
// tb_uart_rx_sipo_param: directed frames into four receiver configurations with hand-computed results
module tb_uart_rx_sipo_param;
    logic baud_clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    uart_rx_sipo_param_if #(.DATA_BITS(8)) b0 ();
    uart_rx_sipo_param_if #(.DATA_BITS(7)) b1 ();
    uart_rx_sipo_param_if #(.DATA_BITS(8)) b2 ();
    uart_rx_sipo_param_if #(.DATA_BITS(8)) b3 ();
    uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (.baud_clk(baud_clk), .rst(rst), .bus(b0.slave));
    uart_rx_sipo_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u1 (.baud_clk(baud_clk), .rst(rst), .bus(b1.slave));
    uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u2 (.baud_clk(baud_clk), .rst(rst), .bus(b2.slave));
    uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u3 (.baud_clk(baud_clk), .rst(rst), .bus(b3.slave));
    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) b0.rx_in = v;
        else if (sel == 1) b1.rx_in = v;
        else if (sel == 2) b2.rx_in = v;
        else b3.rx_in = v;
    endtask
    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            tick();
        end
        set_rx(sel, 1'b1);
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        {b0.rx_in, b1.rx_in, b2.rx_in, b3.rx_in} = 4'hF;
        {b0.data_ready, b1.data_ready, b2.data_ready, b3.data_ready} = 4'hF;
        #1;
        check("rst_valid_async", b0.data_valid, 0);
        tick();
        tick();
        check("rst_dout", b0.data_out, 0);
        check("rst_flags", {b0.parity_err, b0.frame_err, b0.overrun, b0.active}, 0);
        rst = 1'b0;
        send(0, {1'b1, 8'hA5, 1'b0}, 9);
        check("a5_not_early", b0.data_valid, 0);
        check("a5_active", b0.active, 1);
        send(0, 16'h1, 1);
        check("a5_valid", b0.data_valid, 1);
        check("a5_data", b0.data_out, 32'hA5);
        check("a5_errs", {b0.parity_err, b0.frame_err, b0.overrun, b0.active}, 0);
        tick();
        check("a5_one_cycle", b0.data_valid, 0);
        send(1, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
        check("even_bad_data", b1.data_out, 32'h55);
        check("even_bad_perr", b1.parity_err, 1);
        tick();
        send(1, {1'b1, 1'b0, 7'h55, 1'b0}, 10);
        check("even_ok_perr", b1.parity_err, 0);
        check("even_ok_valid", b1.data_valid, 1);
        send(2, {1'b0, 1'b1, 8'h3C, 1'b0}, 10);
        check("stop2_pending", b2.data_valid, 0);
        send(2, 16'h0, 1);
        check("stop2_data", b2.data_out, 32'h3C);
        check("stop2_ferr", b2.frame_err, 1);
        send(3, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        check("odd_ok_perr", b3.parity_err, 0);
        tick();
        send(3, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        check("odd_bad_perr", b3.parity_err, 1);
        b0.data_ready = 1'b0;
        send(0, {1'b1, 8'h11, 1'b0}, 10);
        check("ovr_first_data", b0.data_out, 32'h11);
        send(0, {1'b1, 8'h22, 1'b0}, 10);
        check("ovr_pulse", b0.overrun, 1);
        check("ovr_hold_data", b0.data_out, 32'h11);
        tick();
        check("ovr_one_cycle", b0.overrun, 0);
        check("ovr_valid_held", b0.data_valid, 1);
        send(0, {1'b1, 8'h22, 1'b0}, 9);
        b0.data_ready = 1'b1;
        send(0, 16'h1, 1);
        check("swap_data", b0.data_out, 32'h22);
        check("swap_valid", b0.data_valid, 1);
        check("swap_no_ovr", b0.overrun, 0);
        tick();
        check("swap_consumed", b0.data_valid, 0);
        send(0, {1'b1, 8'hFF, 1'b0}, 5);
        check("midframe_active", b0.active, 1);
        rst = 1'b1;
        #1;
        check("midframe_rst_active", b0.active, 0);
        tick();
        check("midframe_rst_valid", b0.data_valid, 0);
        rst = 1'b0;
        send(0, {1'b1, 8'h81, 1'b0}, 9);
        check("post_rst_no_ovr", {b0.data_valid, b0.overrun}, 0);
        send(0, 16'h1, 1);
        check("post_rst_data", b0.data_out, 32'h81);
        check("post_rst_valid", b0.data_valid, 1);
        tick();
        send(0, 16'h0, 10);
        check("break_data", b0.data_out, 0);
        check("break_ferr", b0.frame_err, 1);
        check("break_valid", b0.data_valid, 1);
        tick();
        tick();
        check("idle_after_break", b0.active, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
